uart_rx_div: RTL and testbench
==============================

# uart_rx_div

UART receiver driven by the same divisor convention as the team's clock divider: with divisor `div`, one bit period is 2·(div+1) `clk` cycles, exactly the period of the divided clock, so transmitter and receiver configured with the same `div` agree on baud. Receives 8N1-style frames (start, DATA_BITS data LSB first, one stop) from the HPS-to-FPGA UART path. Presents bytes on a valid/ready output and flags framing errors and overruns.

## Interface
- CLK_CNT_WIDTH, 16, width of `div` and the internal half-bit counter
- DATA_BITS, 8, data bits per frame (5..9)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- div  in  CLK_CNT_WIDTH  half-bit period minus one (H = div+1 cycles); captured at start-bit detection
- rx  in  1  serial input, idle high, asynchronous to clk
- data_out  out  DATA_BITS  received byte, stable while out_valid=1
- out_valid  out  1  byte available; held until accepted
- out_ready  in  1  consumer accepts when out_valid & out_ready on a rising edge
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: good frame completed while out_valid still 1
- busy  out  1  high in any state other than IDLE

## Operation
- Reset values: data_out=0, out_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchronizer flops=1, counter=0.
- rx passes through a 2-flop synchronizer (rs); edge detect uses rs and its previous value rs_d.
- States:
  - IDLE: on rs_d=1 & rs=0 (cycle E) latch div into div_r, clear counter → START.
  - START: count H cycles; at cycle E+H sample rs: 0 → DATA (bit index 0), 1 → IDLE (glitch rejected, no flags).
  - DATA: count 2H cycles per bit; bit i sampled at E+H+2H·(i+1), shifted in LSB first; after bit DATA_BITS-1 → STOP.
  - STOP: sample at E+H+2H·(DATA_BITS+1). rs=1: good frame. rs=0: frame_err pulse, byte discarded. Either way → IDLE.
- Good frame: if out_valid=0 or out_ready=1 that same cycle, data_out ← byte and out_valid=1 next cycle; else overrun pulse, byte discarded, data_out/out_valid unchanged.
- out_valid clears on the cycle after out_valid & out_ready unless a new byte is loaded that same edge (then stays 1 with new data).
- Counter: single CLK_CNT_WIDTH counter compared with div_r, wraps to 0 on match; a phase bit selects half/full bit. No overflow possible since counter never exceeds div_r.
- After a framing error with rx held low (break), no new start is detected until rs returns high and falls again.
- div changes mid-frame have no effect until the next start detection.

## Timing
- Pin-to-rs latency: 2 cycles.
- For div=d, H=d+1: out_valid rises at cycle E+H·(2·DATA_BITS+3)+1 relative to start edge detection E. div=0, DATA_BITS=8: E+20.
- Minimum supported div=0 (2 cycles/bit).
- frame_err/overrun: exactly one cycle, coincident with the cycle out_valid would have been loaded.
- busy falls on the cycle after the stop sample; next start edge may be detected on that cycle.
- Asynchronous reset mid-frame: all outputs to reset values immediately; partial byte discarded; next falling edge after release starts a fresh frame.

## Test plan
- div=3 (8 clk/bit), send 0xA5 with out_ready=1 → data_out=0xA5, out_valid one cycle at E+77, no flags.
- div=3, send 0x3C, 0xC3 back-to-back, out_ready=0 → first byte 0x3C held; second frame gives overrun pulse, data_out stays 0x3C; assert out_ready → out_valid falls next cycle.
- div=3, send 0x55 with stop bit forced low → frame_err pulse at stop sample, out_valid stays 0; hold rx low 40 cycles then release, send 0x12 → 0x12 received cleanly.
- div=3, 3-cycle low glitch on idle rx → no out_valid, no flags, busy high for ≤4 cycles then 0.
- div=0, send 0xFF and 0x00 → both received; out_valid at E+20 each.
- Assert reset mid-data of 0x81 (div=5), release, send 0x7E → outputs 0 during reset, only 0x7E delivered.

Source files
------------

// File: rtl/uart_rx_div.sv
// UART receiver (start, DATA_BITS data LSB first, one stop) whose bit period is 2*(div+1) clk
// cycles, matching the divided clock; delivers bytes on a valid/ready port.
module uart_rx_div #(
    parameter int unsigned CLK_CNT_WIDTH = 16,
    parameter int unsigned DATA_BITS     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CLK_CNT_WIDTH-1:0] div,
    input  logic                     rx,
    output logic [DATA_BITS-1:0]     data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     busy
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic                     rx_meta_q, rs_q, rs_dly_q;
    logic [1:0]               state_q, state_d;
    logic [CLK_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CLK_CNT_WIDTH-1:0] div_q, div_d;
    logic                     phase_q, phase_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [DATA_BITS-1:0]     shift_q, shift_d;
    logic [DATA_BITS-1:0]     data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic                     ovr_q, ovr_d;
    logic                     cnt_hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        cnt_hit = (cnt_q == div_q);

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (rs_dly_q && !rs_q) begin
                    div_d   = div;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_hit) begin
                    cnt_d = '0;
                    if (!rs_q) begin
                        idx_d   = '0;
                        phase_d = 1'b0;
                        state_d = StData;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CLK_CNT_WIDTH'(1);
                end
            end
            StData: begin
                if (cnt_hit) begin
                    // Two half-bit wraps per bit; sample on the second.
                    cnt_d   = '0;
                    phase_d = !phase_q;
                    if (phase_q) begin
                        shift_d = {rs_q, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IdxW'(DATA_BITS - 1)) begin
                            state_d = StStop;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CLK_CNT_WIDTH'(1);
                end
            end
            StStop: begin
                if (cnt_hit) begin
                    cnt_d   = '0;
                    phase_d = !phase_q;
                    if (phase_q) begin
                        state_d = StIdle;
                        if (!rs_q) begin
                            ferr_d = 1'b1;
                        end else if (!valid_q || out_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CLK_CNT_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rs_q      <= 1'b1;
            rs_dly_q  <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= '0;
            phase_q   <= 1'b0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rs_q      <= rx_meta_q;
            rs_dly_q  <= rs_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_div.sv
// Directed and randomized frames for uart_rx_div; expected bytes and event cycles come from
// frame-timing arithmetic (edge seen 2 cycles after the pin, byte ready H*(2*DB+3)+1 later).
module tb_uart_rx_div;

    localparam int CW = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] div = '0;
    logic          rx = 1'b1;
    logic [DB-1:0] data_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx_div #(
        .CLK_CNT_WIDTH(CW),
        .DATA_BITS    (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .div      (div),
        .rx       (rx),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;

    int            rise_cyc_q[$];
    logic [DB-1:0] rise_dat_q[$];
    int            valid_cnt, ferr_cnt, ferr_cyc, ovr_cnt, ovr_cyc, busy_cnt;
    logic          prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rise_cyc_q.delete();
        rise_dat_q.delete();
        valid_cnt = 0;
        ferr_cnt  = 0;
        ferr_cyc  = -1;
        ovr_cnt   = 0;
        ovr_cyc   = -1;
        busy_cnt  = 0;
    endtask

    // Advance one cycle and log output events seen in the new cycle.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (out_valid && !prev_valid) begin
            rise_cyc_q.push_back(cyc);
            rise_dat_q.push_back(data_out);
        end
        if (out_valid) valid_cnt++;
        if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
        if (overrun) begin ovr_cnt++; ovr_cyc = cyc; end
        if (busy) busy_cnt++;
        prev_valid = out_valid;
    endtask

    // Drive frame bits 0..last (0 = start, 1..DB = data, DB+1 = stop), 2H cycles each.
    task automatic send_bits(input logic [DB-1:0] b, input logic stop, input int last,
                             input bit scramble);
        int h;
        h = int'(div) + 1;
        start_cyc = cyc;
        for (int j = 0; j <= last; j++) begin
            if (scramble && j == 2) div = CW'($urandom_range(0, 7));
            if (j == 0) rx = 1'b0;
            else if (j <= DB) rx = b[j-1];
            else rx = stop;
            repeat (2 * h) tick();
        end
        rx = 1'b1;
    endtask

    function automatic int exp_ready(input int start, input int h);
        return start + 2 + h * (2 * DB + 3) + 1;
    endfunction

    initial begin
        int h, s1, s2;
        logic [DB-1:0] b;
        clear_mon();

        // Reset values
        repeat (3) tick();
        check("rst_data", data_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (5) tick();

        // 0xA5, div=3, consumer always ready
        div = 3; h = 4; out_ready = 1'b1;
        clear_mon();
        send_bits(8'hA5, 1'b1, DB + 1, 0);
        repeat (2 * h + 6) tick();
        check("a5_nrise", rise_cyc_q.size(), 1);
        check("a5_cyc", rise_cyc_q[0], exp_ready(start_cyc, h));
        check("a5_cyc77", rise_cyc_q[0] - (start_cyc + 2), 77);
        check("a5_data", rise_dat_q[0], 8'hA5);
        check("a5_vcnt", valid_cnt, 1);
        check("a5_flags", ferr_cnt + ovr_cnt, 0);

        // Back-to-back with consumer stalled: second frame overruns
        out_ready = 1'b0;
        clear_mon();
        send_bits(8'h3C, 1'b1, DB + 1, 0);
        s1 = start_cyc;
        send_bits(8'hC3, 1'b1, DB + 1, 0);
        s2 = start_cyc;
        repeat (2 * h + 6) tick();
        check("ovr_nrise", rise_cyc_q.size(), 1);
        check("ovr_rise_cyc", rise_cyc_q[0], exp_ready(s1, h));
        check("ovr_cnt", ovr_cnt, 1);
        check("ovr_cyc", ovr_cyc, exp_ready(s2, h));
        check("ovr_hold_data", data_out, 8'h3C);
        check("ovr_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("ovr_accept", out_valid, 0);

        // Framing error, then a break, then a clean frame
        clear_mon();
        send_bits(8'h55, 1'b0, DB + 1, 0);
        s1 = start_cyc;
        rx = 1'b0;
        repeat (40) tick();
        check("fe_cnt", ferr_cnt, 1);
        check("fe_cyc", ferr_cyc, exp_ready(s1, h));
        check("fe_novalid", valid_cnt, 0);
        check("fe_break_idle", busy, 0);
        rx = 1'b1;
        repeat (10) tick();
        clear_mon();
        send_bits(8'h12, 1'b1, DB + 1, 0);
        repeat (2 * h + 6) tick();
        check("fe_next_data", rise_dat_q[0], 8'h12);
        check("fe_next_cyc", rise_cyc_q[0], exp_ready(start_cyc, h));
        check("fe_next_flags", ferr_cnt + ovr_cnt, 0);

        // 3-cycle glitch on idle line is rejected after the half-bit
        clear_mon();
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (20) tick();
        check("gl_nrise", rise_cyc_q.size(), 0);
        check("gl_flags", ferr_cnt + ovr_cnt, 0);
        check("gl_busy", busy_cnt, h);
        check("gl_idle", busy, 0);

        // div=0: two cycles per bit
        div = 0; h = 1;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? 8'hFF : 8'h00;
            clear_mon();
            send_bits(b, 1'b1, DB + 1, 0);
            repeat (2 * h + 6) tick();
            check("d0_data", rise_dat_q[0], b);
            check("d0_e20", rise_cyc_q[0] - (start_cyc + 2), 20);
        end

        // Reset mid-data discards the partial byte
        div = 5; h = 6;
        clear_mon();
        send_bits(8'h81, 1'b1, 4, 0);
        reset = 1'b1;
        #1;
        check("mr_busy", busy, 0);
        check("mr_valid", out_valid, 0);
        check("mr_data", data_out, 0);
        repeat (4) tick();
        reset = 1'b0;
        repeat (5) tick();
        send_bits(8'h7E, 1'b1, DB + 1, 0);
        repeat (2 * h + 6) tick();
        check("mr_nrise", rise_cyc_q.size(), 1);
        check("mr_new", rise_dat_q[0], 8'h7E);
        check("mr_cyc", rise_cyc_q[0], exp_ready(start_cyc, h));

        // Random bytes and divisors; div is scrambled mid-frame and must be ignored
        for (int k = 0; k < 6; k++) begin
            div = CW'($urandom_range(0, 4));
            h = int'(div) + 1;
            b = DB'($urandom);
            clear_mon();
            send_bits(b, 1'b1, DB + 1, 1);
            repeat (2 * h + 6) tick();
            check("rnd_nrise", rise_cyc_q.size(), 1);
            check("rnd_data", rise_dat_q[0], b);
            check("rnd_cyc", rise_cyc_q[0], exp_ready(start_cyc, h));
            check("rnd_flags", ferr_cnt + ovr_cnt, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
